priority_unpack: RTL

PRIORITY_UNPACK -- requirements
Module: priority_unpack

---
 rtl/priority_unpack.sv | 117 +++++++++++
 1 files changed

// File: rtl/priority_unpack.sv
// Rebuilds a bit vector from a highest-first stream of set-bit indices.
// One frame is collected per ACC phase and presented in HOLD.
module priority_unpack #(
  parameter int DW = 32,
  parameter int AW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_index,
  input  logic          in_empty,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_vec,
  output logic [AW:0]   out_count,
  output logic          out_err
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [AW:0] LIM = (AW+1)'(DW - 1);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t        state;
  logic [DW-1:0] acc;
  logic [AW:0]   cnt;
  logic          err;
  logic [AW-1:0] prev;
  logic          has_prev;
  logic          has_beat;
  logic          rdy;
  logic          vld;

  logic          take;
  logic          oor;
  logic          ord;
  logic          emp_bad;
  logic          bad;
  logic [DW-1:0] hot;

  assign in_ready  = rdy;
  assign out_valid = vld;
  assign out_vec   = acc;
  assign out_count = cnt;
  assign out_err   = err;

  assign take = in_valid & rdy;
  assign hot  = {{(DW-1){1'b0}}, 1'b1} << in_index;

  // Indices must fall strictly and stay inside the vector;
  // an empty beat is legal only as the whole frame.
  always_comb begin
    oor     = {1'b0, in_index} > LIM;
    ord     = has_prev && (in_index >= prev);
    emp_bad = !(!has_beat && in_last);
    bad     = in_empty ? emp_bad : (oor | ord);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      prev     <= '0;
      has_prev <= 1'b0;
      has_beat <= 1'b0;
      rdy      <= 1'b1;
      vld      <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (take) begin
            has_beat <= 1'b1;
            if (bad) begin
              err <= 1'b1;
            end else if (!in_empty) begin
              acc      <= acc | hot;
              cnt      <= cnt + ONE;
              prev     <= in_index;
              has_prev <= 1'b1;
            end
            if (in_last) begin
              state <= HOLD;
              rdy   <= 1'b0;
              vld   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state    <= ACC;
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            prev     <= '0;
            has_prev <= 1'b0;
            has_beat <= 1'b0;
            rdy      <= 1'b1;
            vld      <= 1'b0;
          end
        end
        default: begin
          state <= ACC;
          rdy   <= 1'b1;
          vld   <= 1'b0;
        end
      endcase
    end
  end

endmodule
